// File: rtl/icache_sa_burst_pkg.sv
// icache_sa_burst_pkg: FSM state encoding and width helper shared by the instruction cache files
package icache_sa_burst_pkg;
    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, MISS, REFILL, RESP} state_e;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/icache_plru.sv
// icache_plru: per-set pseudo-LRU replacement state for 1, 2 or 4 ways
module icache_plru import icache_sa_burst_pkg::*; #(
    parameter int WAYS = 2,
    parameter int SETS = 256,
    parameter int IDX_W = clog2(SETS),
    parameter int WAY_W = (WAYS > 1) ? clog2(WAYS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index,
    input  logic [WAY_W-1:0] touch_way,
    input  logic             touch_en,
    output logic [WAY_W-1:0] victim
);
    localparam int PW = (WAYS > 1) ? WAYS - 1 : 1;
    logic [SETS*PW-1:0] bits_q;
    logic [PW-1:0]      cur, nxt;
    assign cur = bits_q[index*PW +: PW];
    generate
        if (WAYS == 4) begin : g_tree
            // bit0 picks the half holding the victim, bits 1/2 pick within each half
            assign victim = cur[0] ? {1'b1, cur[2]} : {1'b0, cur[1]};
            assign nxt = touch_way[1] ? {~touch_way[0], cur[1], 1'b0} : {cur[2], ~touch_way[0], 1'b1};
        end else if (WAYS == 2) begin : g_bit
            assign victim = cur;
            assign nxt = ~touch_way;
        end else begin : g_dm
            assign victim = '0;
            assign nxt = cur;
        end
    endgenerate
    always_ff @(posedge clk) begin
        if (rst) bits_q <= '0;
        else if (touch_en) bits_q[index*PW +: PW] <= nxt;
    end
endmodule

// File: rtl/icache_sa_burst.sv
// icache_sa_burst: N-way set-associative I-cache with burst line refill, redirect cancel and full invalidate.
// Defining ICACHE_PERF_EN adds the perf_hit/perf_miss lookup counters.
module icache_sa_burst import icache_sa_burst_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WAYS = 2,
    parameter int SETS = 256,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_cancel,
    output logic              cpu_ready,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              inv_req,
    output logic              inv_busy,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rlast
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]       perf_hit,
    output logic [31:0]       perf_miss
`endif
);
    localparam int OFF_W = clog2(LINE_WORDS);
    localparam int IDX_W = clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam int WAY_W = (WAYS > 1) ? clog2(WAYS) : 1;

    state_e            st_q, st_d;
    logic [ADDR_W-1:0] addr_q;
    logic [IDX_W-1:0]  init_q;
    logic [OFF_W-1:0]  beat_q;
    logic [WAY_W-1:0]  vic_q, fill_w, plru_vic, hit_w;
    logic [WAYS-1:0]   vld_q, hit_v;
    logic [TAG_W-1:0]  tag_q [WAYS];
    logic [DATA_W-1:0] rd_q [WAYS];
    logic [DATA_W-1:0] cap_q, hit_d;
    logic              cnl_q, inv_q, hit, acc, inv_any, fill_beat, refill_done;
    logic [IDX_W-1:0]  idx_a, c_idx;
    logic [OFF_W-1:0]  off_a, c_off;
    logic [TAG_W-1:0]  tag_a;

    logic [WAYS-1:0]   vld_mem [SETS];
    logic [TAG_W-1:0]  tag_mem [WAYS][SETS];
    logic [DATA_W-1:0] dat_mem [WAYS][SETS*LINE_WORDS];

    assign idx_a = addr_q[OFF_W+2 +: IDX_W];
    assign off_a = addr_q[2 +: OFF_W];
    assign tag_a = addr_q[ADDR_W-1 -: TAG_W];
    assign c_idx = cpu_addr[OFF_W+2 +: IDX_W];
    assign c_off = cpu_addr[2 +: OFF_W];
    assign inv_any = inv_req | inv_q;
    assign acc = cpu_req & cpu_ready;
    assign fill_beat = st_q == REFILL && mem_rvalid;
    // the line completes on the beat count; mem_rlast is advisory only
    assign refill_done = fill_beat && &beat_q;

    always_comb begin
        hit_w = '0;
        hit_d = '0;
        for (int w = 0; w < WAYS; w++) begin
            hit_v[w] = vld_q[w] && tag_q[w] == tag_a;
            if (hit_v[w]) begin
                hit_w = w[WAY_W-1:0];
                hit_d = rd_q[w];
            end
        end
        hit = |hit_v;
    end

    always_comb begin
        fill_w = plru_vic;
        for (int w = WAYS - 1; w >= 0; w--) if (!vld_q[w]) fill_w = w[WAY_W-1:0];
    end

    icache_plru #(.WAYS(WAYS), .SETS(SETS), .IDX_W(IDX_W), .WAY_W(WAY_W)) u_plru (
        .clk       (clk),
        .rst       (rst),
        .index     (idx_a),
        .touch_way (st_q == LOOKUP ? hit_w : vic_q),
        .touch_en  ((st_q == LOOKUP && hit) || refill_done),
        .victim    (plru_vic)
    );

    always_ff @(posedge clk) begin
        if (rst) st_q <= INIT;
        else st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        case (st_q)
            INIT:    st_d = &init_q ? IDLE : INIT;
            IDLE:    st_d = inv_any ? INIT : cpu_req ? LOOKUP : IDLE;
            LOOKUP:  st_d = !hit ? MISS : inv_any ? INIT : cpu_req ? LOOKUP : IDLE;
            MISS:    st_d = mem_gnt ? REFILL : MISS;
            REFILL:  st_d = refill_done ? RESP : REFILL;
            RESP:    st_d = inv_any ? INIT : IDLE;
            default: st_d = INIT;
        endcase
    end

    always_comb begin
        cpu_ready = (st_q == IDLE || (st_q == LOOKUP && hit)) && !inv_any;
        cpu_rvalid = ((st_q == LOOKUP && hit) || (st_q == RESP && !cnl_q)) && !cpu_cancel;
        cpu_rdata = !cpu_rvalid ? '0 : (st_q == RESP) ? cap_q : hit_d;
        inv_busy = st_q == INIT && !rst;
        mem_req = st_q == MISS;
        mem_addr = mem_req ? {addr_q[ADDR_W-1:OFF_W+2], (OFF_W+2)'(0)} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_q <= '0;
            beat_q <= '0;
            inv_q <= 1'b0;
            cnl_q <= 1'b0;
        end else begin
            init_q <= (st_q == INIT) ? init_q + IDX_W'(1) : '0;
            beat_q <= (st_q == REFILL) ? beat_q + OFF_W'(mem_rvalid) : '0;
            // an invalidate arriving mid-miss is remembered until the walk starts
            inv_q <= st_d != INIT && (inv_q || inv_req);
            cnl_q <= (st_q == LOOKUP) ? cpu_cancel : cnl_q | cpu_cancel;
        end
    end

    always_ff @(posedge clk) begin
        if (acc) addr_q <= cpu_addr;
        if (st_q == LOOKUP) vic_q <= fill_w;
        if (fill_beat && beat_q == off_a) cap_q <= mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            vld_q <= vld_mem[c_idx];
            for (int w = 0; w < WAYS; w++) begin
                tag_q[w] <= tag_mem[w][c_idx];
                rd_q[w] <= dat_mem[w][{c_idx, c_off}];
            end
        end
        if (st_q == INIT) vld_mem[init_q] <= '0;
        if (refill_done) begin
            vld_mem[idx_a] <= vld_q | (WAYS'(1) << vic_q);
            tag_mem[vic_q][idx_a] <= tag_a;
        end
        if (fill_beat) dat_mem[vic_q][{idx_a, beat_q}] <= mem_rdata;
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q <= '0;
            miss_cnt_q <= '0;
        end else if (st_q == LOOKUP) begin
            hit_cnt_q <= hit_cnt_q + 32'(hit);
            miss_cnt_q <= miss_cnt_q + 32'(!hit);
        end
    end
    assign perf_hit = hit_cnt_q;
    assign perf_miss = miss_cnt_q;
`endif

    logic unused_ok;
    assign unused_ok = ^{addr_q[1:0], mem_rlast};
endmodule

// File: tb/tb_icache_sa_burst.sv
// tb_icache_sa_burst: directed checks of fill, hit streaming, LRU eviction, cancel and invalidate
module tb_icache_sa_burst;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req, cpu_cancel, cpu_ready, cpu_rvalid, inv_req, inv_busy;
    logic        mem_req, mem_gnt, mem_rvalid, mem_rlast;
    logic [31:0] cpu_addr, cpu_rdata, mem_addr, mem_rdata;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit, perf_miss;
`endif
    int          n_chk = 0, n_err = 0, req_cnt = 0, rv_cnt = 0;
    logic [31:0] last_ma = '0;

    icache_sa_burst dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_cancel (cpu_cancel),
        .cpu_ready  (cpu_ready),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .inv_req    (inv_req),
        .inv_busy   (inv_busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_rlast  (mem_rlast)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hit   (perf_hit),
        .perf_miss  (perf_miss)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // memory: grant mid-cycle, then four beats (one idle gap) of data 0xD0000000|addr
    initial begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        mem_rlast = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                req_cnt++;
                last_ma = mem_addr;
                mem_gnt = 1'b1;
                @(posedge clk); #1;
                mem_gnt = 1'b0;
                for (int b = 0; b < 4; b++) begin
                    if (b == 2) begin
                        mem_rvalid = 1'b0;
                        @(posedge clk); #1;
                    end
                    mem_rvalid = 1'b1;
                    mem_rdata = 32'hD000_0000 | (last_ma + b * 4);
                    mem_rlast = (b == 3);
                    @(posedge clk); #1;
                end
                mem_rvalid = 1'b0;
                mem_rlast = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cpu_rvalid) rv_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic busy_count(output int c, output logic rdy);
        c = 0;
        rdy = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            rdy = cpu_ready;
            if (!inv_busy) break;
            c++;
        end
        @(posedge clk); #1;
    endtask

    // act: 0 plain, 1 cancel during refill, 2 invalidate during refill
    task automatic fetch(input logic [31:0] a, input int act, output bit got, output logic [31:0] d, output int lat);
        int  n;
        bit  done;
        got = 1'b0;
        d = '0;
        lat = -1;
        n = 0;
        done = 1'b0;
        cpu_req = 1'b1;
        cpu_addr = a;
        @(negedge clk);
        while (!cpu_ready && n < 600) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        if (n >= 600) chk("ready_timeout", 32'(n), 0);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (mem_rvalid && act == 1) cpu_cancel = 1'b1;
            if (mem_rvalid && act == 2) inv_req = 1'b1;
            if (cpu_rvalid) begin
                got = 1'b1;
                d = cpu_rdata;
                lat = i;
            end
            done = got || cpu_ready;
            @(posedge clk); #1;
            cpu_cancel = 1'b0;
            inv_req = 1'b0;
        end
        if (!done) chk("resp_timeout", 32'(done), 1);
    endtask

    bit          got;
    logic [31:0] d;
    logic        rdy;
    int          lat, c, r0, v0;

    initial begin
        cpu_req = 1'b0;
        cpu_addr = '0;
        cpu_cancel = 1'b0;
        inv_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", cpu_ready, 0);
        chk("rst_busy", inv_busy, 0);
        chk("rst_mreq", mem_req, 0);
        chk("rst_rvalid", cpu_rvalid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        busy_count(c, rdy);
        chk("init_cycles", c, 256);
        chk("init_ready", rdy, 1);

        fetch(32'h1000, 0, got, d, lat);
        chk("s1_got", got, 1);
        chk("s1_data", d, 32'hD000_1000);
        chk("s1_mreq", req_cnt, 1);
        chk("s1_maddr", last_ma, 32'h1000);

        r0 = req_cnt;
        for (int i = 0; i < 3; i++) begin
            cpu_req = 1'b1;
            cpu_addr = 32'h1004 + i * 4;
            @(posedge clk); #1;
            cpu_req = 1'b0;
            @(negedge clk);
            chk("b2b_rvalid", cpu_rvalid, 1);
            chk("b2b_data", cpu_rdata, 32'hD000_1004 + i * 4);
            chk("b2b_ready", cpu_ready, 1);
        end
        @(posedge clk); #1;
        chk("s2_no_mreq", req_cnt, r0);
`ifdef ICACHE_PERF_EN
        chk("perf_hit", perf_hit, 3);
        chk("perf_miss", perf_miss, 1);
`endif

        fetch(32'h2000, 0, got, d, lat);
        chk("s3_2000_data", d, 32'hD000_2000);
        fetch(32'h3000, 0, got, d, lat);
        chk("s3_3000_data", d, 32'hD000_3000);
        r0 = req_cnt;
        fetch(32'h2000, 0, got, d, lat);
        chk("s3_2000_hit", req_cnt, r0);
        chk("s3_2000_lat", lat, 0);
        chk("s3_2000_hdata", d, 32'hD000_2000);
        fetch(32'h1000, 0, got, d, lat);
        chk("s3_1000_miss", req_cnt, r0 + 1);
        chk("s3_1000_maddr", last_ma, 32'h1000);

        v0 = rv_cnt;
        fetch(32'h4008, 1, got, d, lat);
        chk("s4_cancel_got", got, 0);
        chk("s4_cancel_rv", rv_cnt, v0);
        r0 = req_cnt;
        fetch(32'h4008, 0, got, d, lat);
        chk("s4_hit", req_cnt, r0);
        chk("s4_data", d, 32'hD000_4008);

        cpu_req = 1'b1;
        cpu_addr = 32'h4004;
        cpu_cancel = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        cpu_cancel = 1'b0;
        @(negedge clk);
        chk("idle_cancel_rv", cpu_rvalid, 1);
        chk("idle_cancel_data", cpu_rdata, 32'hD000_4004);
        @(posedge clk); #1;
        cpu_req = 1'b1;
        cpu_addr = 32'h4008;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        cpu_cancel = 1'b1;
        @(negedge clk);
        chk("lookup_cancel_rv", cpu_rvalid, 0);
        @(posedge clk); #1;
        cpu_cancel = 1'b0;

        fetch(32'h5000, 2, got, d, lat);
        chk("s5_got", got, 1);
        chk("s5_data", d, 32'hD000_5000);
        busy_count(c, rdy);
        chk("s5_inv_cycles", c, 256);
        r0 = req_cnt;
        fetch(32'h5000, 0, got, d, lat);
        chk("s5_refetch_miss", req_cnt, r0 + 1);
        chk("s5_refetch_data", d, 32'hD000_5000);

        inv_req = 1'b1;
        cpu_req = 1'b1;
        cpu_addr = 32'h5000;
        @(negedge clk);
        chk("inv_req_ready", cpu_ready, 0);
        @(posedge clk); #1;
        inv_req = 1'b0;
        cpu_req = 1'b0;
        busy_count(c, rdy);
        chk("inv_idle_cycles", c, 256);
        r0 = req_cnt;
        fetch(32'h5000, 0, got, d, lat);
        chk("inv_idle_miss", req_cnt, r0 + 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
